rgb_unpacker: RTL

- Upstream feeder for the RGB FIFO at the head of the grayscale/sobel pipeline.
- Reads 32-bit packed memory words from an input FIFO and unpacks them into 24-bit RGB pixels, at a rate of 3 words to 4 pixels.
- Writes the pixels into the RGB FIFO through its wr_en/din/full interface.
- Counts pixels per frame, re-aligns to a word boundary at each frame end, and pulses frame_done.

---
 rtl/rgb_unpacker.sv | 132 +++++++++++++
 1 files changed

// File: rtl/rgb_unpacker.sv
// rgb_unpacker: turns a stream of 32-bit packed memory words into 24-bit RGB
// pixels (three words become four pixels) and feeds them into the RGB FIFO.
// Also tracks pixel position in the frame, re-aligns to a fresh word after
// the last pixel of every frame and pulses frame_done one cycle later.
module rgb_unpacker #(
    parameter int WORD_DWIDTH = 32,
    parameter int RGB_DWIDTH  = 24,
    parameter int IMG_WIDTH   = 720,
    parameter int IMG_HEIGHT  = 540
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   fifo_in_rd_en,
    input  logic [WORD_DWIDTH-1:0] fifo_in_dout,
    input  logic                   fifo_in_empty,
    output logic                   fifo_out_wr_en,
    output logic [RGB_DWIDTH-1:0]  fifo_out_din,
    input  logic                   fifo_out_full,
    output logic                   frame_done
);

    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    // P0..P2 each consume one word; P3 emits the three bytes left over
    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } phase_t;

    phase_t          r_phase;
    logic [23:0]     r_hold;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_frameDone;

    phase_t          w_phaseNext;
    logic [23:0]     w_holdNext;
    logic [XW-1:0]   w_xNext;
    logic [YW-1:0]   w_yNext;
    logic            w_write;
    logic            w_pop;
    logic            w_lastPixel;
    logic [23:0]     w_pixel;

    // Decide whether this cycle moves a pixel; P3 needs only room downstream
    always_comb begin
        w_write = 1'b0;
        w_pop   = 1'b0;
        if (r_phase == P3) begin
            w_write = !fifo_out_full;
        end else begin
            w_write = !fifo_in_empty && !fifo_out_full;
            w_pop   = w_write;
        end
        w_lastPixel = w_write && (r_x == X_LAST) && (r_y == Y_LAST);
    end

    // State register: phase, leftover bytes, frame position and done pulse
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase     <= P0;
            r_hold      <= 24'd0;
            r_x         <= '0;
            r_y         <= '0;
            r_frameDone <= 1'b0;
        end else begin
            r_phase     <= w_phaseNext;
            r_hold      <= w_holdNext;
            r_x         <= w_xNext;
            r_y         <= w_yNext;
            r_frameDone <= w_lastPixel;
        end
    end

    // Next state: stash unused word bytes, advance position, realign at frame end
    always_comb begin
        w_phaseNext = r_phase;
        w_holdNext  = r_hold;
        w_xNext     = r_x;
        w_yNext     = r_y;
        if (w_write) begin
            case (r_phase)
                P0: begin
                    w_holdNext[7:0] = fifo_in_dout[31:24];
                    w_phaseNext     = P1;
                end
                P1: begin
                    w_holdNext[15:0] = fifo_in_dout[31:16];
                    w_phaseNext      = P2;
                end
                P2: begin
                    w_holdNext  = fifo_in_dout[31:8];
                    w_phaseNext = P3;
                end
                default: begin
                    w_phaseNext = P0;
                end
            endcase
            if (w_lastPixel) begin
                w_xNext     = '0;
                w_yNext     = '0;
                w_phaseNext = P0;
                w_holdNext  = 24'd0;
            end else if (r_x == X_LAST) begin
                w_xNext = '0;
                w_yNext = r_y + 1'b1;
            end else begin
                w_xNext = r_x + 1'b1;
            end
        end
    end

    // Outputs: assemble the pixel from new word plus held bytes, zero when idle or in reset
    always_comb begin
        case (r_phase)
            P0:      w_pixel = fifo_in_dout[23:0];
            P1:      w_pixel = {fifo_in_dout[15:0], r_hold[7:0]};
            P2:      w_pixel = {fifo_in_dout[7:0], r_hold[15:0]};
            default: w_pixel = r_hold;
        endcase
        fifo_in_rd_en  = reset && w_pop;
        fifo_out_wr_en = reset && w_write;
        fifo_out_din   = (reset && w_write) ? w_pixel : '0;
        frame_done     = r_frameDone;
    end

endmodule
